// File: rtl/conv_psum_accumulator.sv
// Sums KERNEL signed partial sums per output pixel, saturates to O_OUT bits and queues
// the result in a FIFO drained by valid/ready. Define CONV_PSUM_RELU_EN to clamp negatives to 0.
module conv_psum_accumulator #(
    parameter int I_PSUM     = 16,
    parameter int O_ACC      = 19,
    parameter int O_OUT      = 16,
    parameter int KERNEL     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [I_PSUM-1:0]         i_psum,
    output logic                      o_in_ready,
    input  logic                      i_clear,
    output logic                      o_valid,
    output logic [O_OUT-1:0]          o_data,
    input  logic                      i_ready,
    output logic [$clog2(KERNEL)-1:0] o_cnt
);
    // state | meaning
    // ACC   | accepting partial sums, building the current pixel
    // HOLD  | finished pixel parked in hold register until the FIFO has room
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int CNT_W = $clog2(KERNEL);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [O_ACC-1:0] SAT_MAX = O_ACC'((64'sd1 <<< (O_OUT - 1)) - 64'sd1);
    localparam logic signed [O_ACC-1:0] SAT_MIN = ~SAT_MAX;

    logic [0:0]               state;
    logic signed [O_ACC-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic [O_OUT-1:0]         hold;
    logic [O_OUT-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W:0]           count;

    logic signed [O_ACC-1:0]  psum_ext;
    logic signed [O_ACC-1:0]  sum;
    logic [O_OUT-1:0]         sat_val;
    logic [O_OUT-1:0]         result;
    logic                     transfer;
    logic                     last;
    logic                     complete;
    logic                     full;
    logic                     pop;
    logic                     space;
    logic                     push;
    logic [O_OUT-1:0]         push_data;

    assign o_in_ready = (state == ST_ACC);
    assign o_valid    = (count != '0);
    assign o_data     = mem[rd_ptr];
    assign o_cnt      = cnt;

    assign psum_ext = {{(O_ACC - I_PSUM){i_psum[I_PSUM-1]}}, i_psum};
    assign sum      = acc + psum_ext;
    assign transfer = i_valid && o_in_ready;
    assign last     = (cnt == CNT_W'(KERNEL - 1));
    assign complete = transfer && !i_clear && last;
    assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop      = o_valid && i_ready;
    assign space    = !full || pop;

    always_comb begin
        sat_val = sum[O_OUT-1:0];
        if (sum > SAT_MAX)
            sat_val = SAT_MAX[O_OUT-1:0];
        else if (sum < SAT_MIN)
            sat_val = SAT_MIN[O_OUT-1:0];
    end

`ifdef CONV_PSUM_RELU_EN
    assign result = sat_val[O_OUT-1] ? '0 : sat_val;
`else
    assign result = sat_val;
`endif

    // A parked result always drains before new input is accepted, so the two push sources never collide.
    always_comb begin
        push      = 1'b0;
        push_data = result;
        if (state == ST_HOLD) begin
            push      = space;
            push_data = hold;
        end else if (complete) begin
            push = space;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_ACC;
            acc    <= '0;
            cnt    <= '0;
            hold   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (i_clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (transfer) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end

            if (state == ST_ACC) begin
                if (complete && !space) begin
                    hold  <= result;
                    state <= ST_HOLD;
                end
            end else if (space) begin
                state <= ST_ACC;
            end

            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Testbench for conv_psum_accumulator: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_conv_psum_accumulator;
    localparam int KERNEL = 3;
    localparam int DEPTH  = 4;
`ifdef CONV_PSUM_RELU_EN
    localparam int NEG_SAT = 0;
`else
    localparam int NEG_SAT = -32768;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [15:0] i_psum;
    logic        o_in_ready;
    logic        i_clear;
    logic        o_valid;
    logic [15:0] o_data;
    logic        i_ready;
    logic [1:0]  o_cnt;

    conv_psum_accumulator dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_psum     (i_psum),
        .o_in_ready (o_in_ready),
        .i_clear    (i_clear),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_cnt      (o_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        bit v; int psum; bit clr; bit rdy;
        bit ev; int ed; bit er; int ec;
    } vec_t;
    vec_t vecs[$];

    // reference model state
    int  out_q[$];
    int  pix[$];
    bit  pending;
    int  pending_val;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int data_now();
        logic signed [15:0] s;
        s = o_data;
        return int'(s);
    endfunction

    task automatic cyc(input bit v, input int ps, input bit c, input bit r);
        logic [31:0] tmp;
        tmp     = ps;
        i_valid = v;
        i_psum  = tmp[15:0];
        i_clear = c;
        i_ready = r;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic add(input bit v, input int ps, input bit c, input bit r,
                       input bit ev, input int ed, input bit er, input int ec);
        vec_t x;
        x.v = v; x.psum = ps; x.clr = c; x.rdy = r;
        x.ev = ev; x.ed = ed; x.er = er; x.ec = ec;
        vecs.push_back(x);
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_psum = '0; i_clear = 1'b0; i_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    function automatic int sat_pixel(input int s);
        int r;
        r = s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef CONV_PSUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic model_step(input bit v, input int ps, input bit c, input bit r);
        bit pop, space;
        int s;
        pop   = (out_q.size() != 0) && r;
        space = (out_q.size() < DEPTH) || pop;
        if (pop) void'(out_q.pop_front());
        if (pending) begin
            if (space) begin
                out_q.push_back(pending_val);
                pending = 0;
            end
        end else if (c) begin
            pix.delete();
        end else if (v) begin
            pix.push_back(ps);
            if (pix.size() == KERNEL) begin
                s = 0;
                foreach (pix[k]) s += pix[k];
                pix.delete();
                if (space) out_q.push_back(sat_pixel(s));
                else begin
                    pending     = 1;
                    pending_val = sat_pixel(s);
                end
            end
        end
    endtask

    initial begin
        int got[$];
        int exp_bp[5];
        int rdy_pct;

        i_rst = 1'b1; i_valid = 1'b0; i_psum = '0; i_clear = 1'b0; i_ready = 1'b0;
        #12;
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_data", data_now(), 0);
        chk("reset_in_ready", int'(o_in_ready), 1);
        chk("reset_cnt", int'(o_cnt), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // v, psum, clr, rdy -> valid, data, in_ready, cnt after the edge
        add(1, 100, 0, 1,  0, 0, 1, 1);
        add(1, 200, 0, 1,  0, 0, 1, 2);
        add(1, 300, 0, 1,  1, 600, 1, 0);
        add(0, 0, 0, 1,    0, 0, 1, 0);
        add(1, 30000, 0, 1, 0, 0, 1, 1);
        add(1, 30000, 0, 1, 0, 0, 1, 2);
        add(1, 30000, 0, 1, 1, 32767, 1, 0);
        add(0, 0, 0, 1,    0, 0, 1, 0);
        add(1, -30000, 0, 1, 0, 0, 1, 1);
        add(1, -30000, 0, 1, 0, 0, 1, 2);
        add(1, -30000, 0, 1, 1, NEG_SAT, 1, 0);
        add(0, 0, 0, 1,    0, 0, 1, 0);
        add(1, -5, 0, 1,   0, 0, 1, 1);
        add(0, 0, 0, 1,    0, 0, 1, 1);
        add(1, 10, 0, 1,   0, 0, 1, 2);
        add(1, 7, 0, 1,    1, 12, 1, 0);
        add(0, 0, 0, 1,    0, 0, 1, 0);
        foreach (vecs[n]) begin
            cyc(vecs[n].v, vecs[n].psum, vecs[n].clr, vecs[n].rdy);
            chk($sformatf("vec%0d_valid", n), int'(o_valid), int'(vecs[n].ev));
            if (vecs[n].ev) chk($sformatf("vec%0d_data", n), data_now(), vecs[n].ed);
            chk($sformatf("vec%0d_in_ready", n), int'(o_in_ready), int'(vecs[n].er));
            chk($sformatf("vec%0d_cnt", n), int'(o_cnt), vecs[n].ec);
        end

        // backpressure: five pixels into a 4-deep FIFO with the consumer stalled
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 3 * k, 0, 0);
            cyc(1, 3 * k, 0, 0);
            cyc(1, 4 * k, 0, 0);
            exp_bp[k-1] = 10 * k;
        end
        chk("bp_in_ready_hold", int'(o_in_ready), 0);
        chk("bp_valid", int'(o_valid), 1);
        chk("bp_head", data_now(), 10);
        cyc(1, 999, 0, 0);
        chk("bp_ignored_cnt", int'(o_cnt), 0);
        chk("bp_still_hold", int'(o_in_ready), 0);
        got.delete();
        for (int k = 0; k < 12; k++) begin
            if (o_valid) got.push_back(data_now());
            cyc(0, 0, 0, 1);
        end
        chk("bp_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk($sformatf("bp_out%0d", k), got[k], exp_bp[k]);
        chk("bp_in_ready_back", int'(o_in_ready), 1);
        chk("bp_drained", int'(o_valid), 0);

        // clear with a same-cycle input
        cyc(1, 5, 0, 1);
        cyc(1, 7, 0, 1);
        chk("clr_cnt_before", int'(o_cnt), 2);
        cyc(1, 9, 1, 1);
        chk("clr_cnt", int'(o_cnt), 0);
        chk("clr_no_output", int'(o_valid), 0);
        cyc(1, 1, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 3, 0, 1);
        chk("clr_next_valid", int'(o_valid), 1);
        chk("clr_next_data", data_now(), 6);
        cyc(0, 0, 0, 1);

        // reset mid-pixel with one result queued
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("rst_pre_valid", int'(o_valid), 1);
        chk("rst_pre_data", data_now(), 3);
        cyc(1, 5, 0, 0);
        cyc(1, 7, 0, 0);
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", int'(o_valid), 0);
        chk("rst_async_data", data_now(), 0);
        chk("rst_async_cnt", int'(o_cnt), 0);
        chk("rst_async_in_ready", int'(o_in_ready), 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        cyc(0, 0, 0, 1);
        chk("rst_no_glitch0", int'(o_valid), 0);
        cyc(0, 0, 0, 1);
        chk("rst_no_glitch1", int'(o_valid), 0);
        cyc(1, 1, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(1, 3, 0, 1);
        chk("rst_next_data", data_now(), 6);
        cyc(0, 0, 0, 1);

        // full FIFO, pixel completes on the same edge as a pop
        for (int k = 1; k <= 4; k++) begin
            cyc(1, k, 0, 0);
            cyc(1, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(1, 5, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk("fp_in_ready", int'(o_in_ready), 1);
        chk("fp_head", data_now(), 2);
        got.delete();
        for (int k = 0; k < 10; k++) begin
            if (o_valid) got.push_back(data_now());
            cyc(0, 0, 0, 1);
        end
        chk("fp_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("fp_out%0d", k), got[k], k + 2);

        // randomized run against the reference model
        do_reset();
        out_q.delete(); pix.delete(); pending = 0; pending_val = 0;
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            bit v, c, r;
            int ps;
            if (n % 200 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
            chk("rnd_valid", int'(o_valid), int'(out_q.size() != 0));
            if (o_valid && out_q.size() != 0) chk("rnd_data", data_now(), out_q[0]);
            chk("rnd_in_ready", int'(o_in_ready), int'(!pending));
            chk("rnd_cnt", int'(o_cnt), pix.size());
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 99) < rdy_pct);
            ps = ($urandom_range(0, 2) == 0) ? (int'($urandom_range(0, 65535)) - 32768)
                                             : (int'($urandom_range(0, 400)) - 200);
            model_step(v, ps, c, r);
            cyc(v, ps, c, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
